// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.
// Walks one BCD digit at a time onto a shared decoder, with a blanking guard between digits.
module display_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    input  logic                    lzb_en,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_tick
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES)
                           ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                           : ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {DRIVE, BLANK} state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [4*NUM_DIGITS-1:0] shadow, pending;
    logic                    pending_valid;
    logic                    wrap;
    logic                    accept;
    logic [NUM_DIGITS-1:0]   anode_next;
    logic [3:0]              bcd_next;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              digit_code;

    assign load_ready = !pending_valid;
    assign accept     = load_valid && load_ready;

    // A digit above 0 is blanked when it and every more significant digit are zero.
    always_comb begin : lzb_scan
        logic all_zero;
        lz_blank = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero && (shadow[4*i +: 4] == 4'h0);
            lz_blank[i] = all_zero && (i != 0);
        end
    end

    always_comb begin
        digit_code = shadow[4*idx +: 4];
        if (lzb_en && lz_blank[idx]) begin
            digit_code = 4'hF;
        end
    end

    // state/idx/cnt name the slot the next edge puts on the outputs.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        wrap       = 1'b0;
        anode_next = '1;
        bcd_next   = 4'hF;
        case (state)
            DRIVE: begin
                anode_next = ~(NUM_DIGITS'(1) << idx);
                bcd_next   = digit_code;
                if (cnt != DRIVE_LAST) begin
                    cnt_next = cnt + 1'b1;
                end else if (BLANK_CYCLES != 0) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                end else begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                    idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    wrap       = (idx == IDX_LAST);
                end
            end
            BLANK: begin
                if (cnt != BLANK_LAST) begin
                    cnt_next = cnt + 1'b1;
                end else begin
                    state_next = DRIVE;
                    cnt_next   = '0;
                    idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    wrap       = (idx == IDX_LAST);
                end
            end
            default: begin
                state_next = DRIVE;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DRIVE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            cnt   <= cnt_next;
        end
    end

    // Frames commit only on the wrap edge so a displayed number never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode         <= '1;
            bcd_out       <= 4'hF;
            frame_tick    <= 1'b0;
            shadow        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            anode      <= anode_next;
            bcd_out    <= bcd_next;
            frame_tick <= wrap;
            if (wrap && pending_valid) begin
                shadow        <= pending;
                pending_valid <= 1'b0;
            end else if (accept) begin
                pending       <= load_data;
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: scan order, load/commit, backpressure,
// leading-zero blanking, asynchronous reset mid-frame and a no-guard variant.
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        lzb_en;
    logic [3:0]  bcd_out;
    logic [3:0]  anode;
    logic        frame_tick;

    logic        nb_load_valid;
    logic [15:0] nb_load_data;
    logic        nb_load_ready;
    logic        nb_lzb_en;
    logic [3:0]  nb_bcd_out;
    logic [3:0]  nb_anode;
    logic        nb_frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .lzb_en     (lzb_en),
        .bcd_out    (bcd_out),
        .anode      (anode),
        .frame_tick (frame_tick)
    );

    display_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) u_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (nb_load_valid),
        .load_data  (nb_load_data),
        .load_ready (nb_load_ready),
        .lzb_en     (nb_lzb_en),
        .bcd_out    (nb_bcd_out),
        .anode      (nb_anode),
        .frame_tick (nb_frame_tick)
    );

    typedef struct {
        logic [15:0] data;
        logic        lzb;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [9];
        logic [15:0] frame_val [6];
        logic [15:0] shown;
        logic [15:0] obs;
        logic [3:0]  ea, eb;
        logic        er;
        logic        ok;
        int          s, d, w;

        vecs[0] = '{16'h0070, 1'b1, 16'hFF70};
        vecs[1] = '{16'h0070, 1'b0, 16'h0070};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFF0};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000};
        vecs[4] = '{16'h00A5, 1'b1, 16'hFFA5};
        vecs[5] = '{16'h0102, 1'b1, 16'hF102};
        vecs[6] = '{16'h1000, 1'b1, 16'h1000};
        vecs[7] = '{16'h0B00, 1'b0, 16'h0B00};
        vecs[8] = '{16'hFC0E, 1'b1, 16'hFC0E};

        frame_val[0] = 16'h0000;
        frame_val[1] = 16'h1234;
        frame_val[2] = 16'h1234;
        frame_val[3] = 16'h1234;
        frame_val[4] = 16'h5678;
        frame_val[5] = 16'h9999;

        rst_n         = 1'b1;
        load_valid    = 1'b0;
        load_data     = 16'h0000;
        lzb_en        = 1'b0;
        nb_load_valid = 1'b0;
        nb_load_data  = 16'h0000;
        nb_lzb_en     = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_bcd", 32'(bcd_out), 32'hF);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        chk("rst_ready", 32'(load_ready), 32'h1);
        chk("rst_nb_anode", 32'(nb_anode), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;

        // Scan order, load/commit at cycle 7, then back-to-back frames under backpressure.
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            s     = (c - 1) % 20;
            d     = s / 5;
            w     = s % 5;
            shown = frame_val[(c - 1) / 20];
            if (w < 4) begin
                ea = ~(4'b0001 << d);
                eb = shown[4*d +: 4];
            end else begin
                ea = 4'hF;
                eb = 4'hF;
            end
            er = !((c >= 8 && c <= 19) || (c >= 61 && c <= 79) || (c >= 81 && c <= 99));
            chk("scan_anode", 32'(anode), 32'(ea));
            chk("scan_bcd", 32'(bcd_out), 32'(eb));
            chk("scan_tick", 32'(frame_tick), 32'(c % 20 == 0));
            chk("scan_ready", 32'(load_ready), 32'(er));
            s  = (c - 1) % 16;
            ea = ~(4'b0001 << (s / 4));
            chk("nb_anode", 32'(nb_anode), 32'(ea));
            chk("nb_bcd", 32'(nb_bcd_out), 32'h0);
            chk("nb_tick", 32'(nb_frame_tick), 32'(c % 16 == 0));
            if (c == 7)  begin load_valid = 1'b1; load_data = 16'h1234; end
            if (c == 8)  load_valid = 1'b0;
            if (c == 60) begin load_valid = 1'b1; load_data = 16'h5678; end
            if (c == 61) load_data = 16'h9999;
            if (c == 81) load_valid = 1'b0;
        end

        // Leading-zero blanking and pass-through vectors.
        for (int v = 0; v < 9; v++) begin
            lzb_en = vecs[v].lzb;
            @(negedge clk);
            load_valid = 1'b1;
            load_data  = vecs[v].data;
            @(negedge clk);
            load_valid = 1'b0;
            chk("vec_accept", 32'(load_ready), 32'h0);
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (load_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("vec_commit_wait", 32'(ok), 32'h1);
            chk("vec_commit_tick", 32'(frame_tick), 32'h1);
            obs = 16'hxxxx;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if ($countones(~anode) > 1) chk("vec_onehot", 32'(anode), 32'hE);
                for (int j = 0; j < 4; j++) begin
                    if (anode[j] == 1'b0) obs[4*j +: 4] = bcd_out;
                end
            end
            chk("vec_display", 32'(obs), 32'(vecs[v].exp));
        end

        // Asynchronous reset while digit 2 is driven and a frame is pending.
        lzb_en = 1'b0;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'h4321;
        @(negedge clk);
        load_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (anode == 4'b1011) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rst_mid_wait", 32'(ok), 32'h1);
        chk("rst_mid_pending", 32'(load_ready), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_anode", 32'(anode), 32'hF);
        chk("rst_mid_bcd", 32'(bcd_out), 32'hF);
        chk("rst_mid_ready", 32'(load_ready), 32'h1);
        chk("rst_mid_tick", 32'(frame_tick), 32'h0);
        #2 rst_n = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            s = (c - 1) % 20;
            d = s / 5;
            w = s % 5;
            if (w < 4) begin
                ea = ~(4'b0001 << d);
                eb = 4'h0;
            end else begin
                ea = 4'hF;
                eb = 4'hF;
            end
            chk("post_rst_anode", 32'(anode), 32'(ea));
            chk("post_rst_bcd", 32'(bcd_out), 32'(eb));
            chk("post_rst_ready", 32'(load_ready), 32'h1);
            chk("post_rst_tick", 32'(frame_tick), 32'(c % 20 == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
